// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - format constants, operand record and unpack helper for the fpu
package fpu_pkg;

  typedef enum logic {FMT_HALF = 1'b0, FMT_SINGLE = 1'b1} fmt_e;
  typedef enum logic {OP_ADD = 1'b0, OP_MUL = 1'b1} op_e;

  localparam int H_EXP_W   = 5;
  localparam int H_MAN_W   = 10;
  localparam int H_BIAS    = 15;
  localparam int H_EXP_MAX = 31;
  localparam int S_EXP_W   = 8;
  localparam int S_MAN_W   = 23;
  localparam int S_BIAS    = 127;
  localparam int S_EXP_MAX = 255;

  localparam logic [31:0] H_QNAN = 32'h0000_7E00;
  localparam logic [31:0] S_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] H_INF  = 32'h0000_7C00;
  localparam logic [31:0] S_INF  = 32'h7F80_0000;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_I = 0;

  // Unrounded significands: bit 48 has weight 1, bit 49 catches add/mul carry
  localparam int SIG_W = 50;
  localparam int EXP_W = 12;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } operand_t;

  function automatic operand_t unpack_operand(input logic [31:0] x, input fmt_e fmt);
    operand_t o;
    logic [22:0] frac;
    if (fmt == FMT_SINGLE) begin
      o.sign = x[31];
      o.exp  = x[30:23];
      frac   = x[22:0];
      o.sig  = {1'b1, frac};
      o.is_nan = (o.exp == 8'(S_EXP_MAX)) && (frac != '0);
      o.is_inf = (o.exp == 8'(S_EXP_MAX)) && (frac == '0);
    end else begin
      o.sign = x[15];
      o.exp  = {3'b000, x[14:10]};
      frac   = {13'b0, x[9:0]};
      o.sig  = {13'b0, 1'b1, x[9:0]};
      o.is_nan = (o.exp == 8'(H_EXP_MAX)) && (frac != '0);
      o.is_inf = (o.exp == 8'(H_EXP_MAX)) && (frac == '0);
    end
    // Subnormals are read as signed zero
    o.is_zero = (o.exp == 8'h00);
    if (o.is_zero) o.sig = '0;
    return o;
  endfunction

endpackage

// File: rtl/fpu_if.sv
// rtl/fpu_if.sv - operand/result bundle between the fpu and its driver
interface fpu_if;
  logic        fpucontrol;
  logic        floatType;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Result;
  logic [3:0]  fpuFlags;

  modport master (output fpucontrol, floatType, A, B, input Result, fpuFlags);
  modport slave  (input fpucontrol, floatType, A, B, output Result, fpuFlags);
endinterface

// File: rtl/fpu_round_pack.sv
// rtl/fpu_round_pack.sv - normalize, round-to-nearest-even and pack one format
module fpu_round_pack
  import fpu_pkg::*;
#(
  parameter fmt_e FMT = FMT_SINGLE
) (
  input  logic                    sign,
  input  logic signed [EXP_W-1:0] exp,
  input  logic [SIG_W-1:0]        sig,
  output logic [31:0]             result,
  output logic [3:0]              flags
);
  localparam int MW   = (FMT == FMT_SINGLE) ? S_MAN_W : H_MAN_W;
  localparam int EW   = (FMT == FMT_SINGLE) ? S_EXP_W : H_EXP_W;
  localparam int EMAX = (FMT == FMT_SINGLE) ? S_EXP_MAX : H_EXP_MAX;
  localparam logic signed [EXP_W-1:0] EMAX_E = EXP_W'(EMAX);
  localparam logic signed [EXP_W-1:0] ZERO_E = '0;
  localparam logic signed [EXP_W-1:0] ONE_E  = EXP_W'(1);

  logic [5:0]              lz;
  logic [SIG_W-1:0]        norm;
  logic signed [EXP_W-1:0] e_norm, e_fin;
  logic [MW-1:0]           man;
  logic [MW:0]             man_rnd;
  logic                    guard, rest, round_up;

  always_comb begin
    lz = '0;
    for (int i = 0; i < SIG_W; i++) begin
      if (sig[i]) lz = 6'(SIG_W - 1 - i);
    end
    // After the shift the leading one sits at the top bit and becomes the hidden bit
    norm     = sig << lz;
    e_norm   = exp + ONE_E - $signed({6'b0, lz});
    man      = norm[SIG_W-2 -: MW];
    guard    = norm[SIG_W-2-MW];
    rest     = |norm[SIG_W-3-MW:0];
    round_up = guard & (rest | man[0]);
    man_rnd  = {1'b0, man} + {{MW{1'b0}}, round_up};
    e_fin    = e_norm + $signed({{(EXP_W-1){1'b0}}, man_rnd[MW]});

    result = '0;
    flags  = '0;
    result[EW+MW] = sign;
    flags[FLAG_N] = sign;
    if (!norm[SIG_W-1] || e_fin <= ZERO_E) begin
      flags[FLAG_Z] = 1'b1;
    end else if (e_fin >= EMAX_E) begin
      result[EW+MW-1:MW] = '1;
      flags[FLAG_V] = 1'b1;
    end else begin
      result[EW+MW-1:MW] = e_fin[EW-1:0];
      result[MW-1:0]     = man_rnd[MW-1:0];
    end
  end
endmodule

// File: rtl/fpu.sv
// rtl/fpu.sv - single-cycle binary16/binary32 add and multiply with registered result
module fpu
  import fpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  fpu_if.slave bus
);
  fmt_e fmt;
  op_e  op;
  operand_t a, b;

  logic [47:0]             prod;
  logic [SIG_W-1:0]        mul_sig, add_sig, big_sig, small_sig, small_shr, sticky_bit, pre_sig;
  logic signed [EXP_W-1:0] mul_exp, pre_exp, bias_e;
  logic [7:0]              big_exp, small_exp;
  logic [23:0]             big_man, small_man;
  logic [8:0]              exp_diff;
  logic                    a_big, big_sign, add_sign, pre_sign;
  logic                    nan, inf, inf_sign;
  logic [31:0]             half_res, single_res, res_d, res_q;
  logic [3:0]              half_flags, single_flags, flags_d, flags_q;

  assign fmt = fmt_e'(bus.floatType);
  assign op  = op_e'(bus.fpucontrol);
  assign a   = unpack_operand(bus.A, fmt);
  assign b   = unpack_operand(bus.B, fmt);

  always_comb begin
    bias_e  = (fmt == FMT_SINGLE) ? EXP_W'(S_BIAS) : EXP_W'(H_BIAS);
    prod    = {24'b0, a.sig} * {24'b0, b.sig};
    mul_sig = (fmt == FMT_SINGLE) ? ({2'b00, prod} << 2) : ({2'b00, prod} << 28);
    mul_exp = $signed({4'b0, a.exp}) + $signed({4'b0, b.exp}) - bias_e;

    a_big     = {a.exp, a.sig} >= {b.exp, b.sig};
    big_exp   = a_big ? a.exp : b.exp;
    big_man   = a_big ? a.sig : b.sig;
    big_sign  = a_big ? a.sign : b.sign;
    small_exp = a_big ? b.exp : a.exp;
    small_man = a_big ? b.sig : a.sig;
    exp_diff  = {1'b0, big_exp} - {1'b0, small_exp};
    big_sig   = {1'b0, big_man, 25'b0};
    small_sig = {1'b0, small_man, 25'b0};
    if (fmt == FMT_HALF) begin
      big_sig   = big_sig << 13;
      small_sig = small_sig << 13;
    end
    // Bits shifted out collapse into bit 0 so rounding still sees them
    small_shr  = small_sig >> exp_diff;
    sticky_bit = {{(SIG_W-1){1'b0}}, |(small_sig & ~({SIG_W{1'b1}} << exp_diff))};
    if (a.sign ^ b.sign) add_sig = big_sig - (small_shr | sticky_bit);
    else                 add_sig = big_sig + (small_shr | sticky_bit);
    add_sign = big_sign;
    if (add_sig == '0) add_sign = a.is_zero & b.is_zero & a.sign & b.sign;

    pre_sig  = (op == OP_MUL) ? mul_sig : add_sig;
    pre_exp  = (op == OP_MUL) ? mul_exp : $signed({4'b0, big_exp});
    pre_sign = (op == OP_MUL) ? (a.sign ^ b.sign) : add_sign;
  end

  fpu_round_pack #(.FMT(FMT_HALF)) u_rp_half (
    .sign(pre_sign), .exp(pre_exp), .sig(pre_sig), .result(half_res), .flags(half_flags)
  );

  fpu_round_pack #(.FMT(FMT_SINGLE)) u_rp_single (
    .sign(pre_sign), .exp(pre_exp), .sig(pre_sig), .result(single_res), .flags(single_flags)
  );

  always_comb begin
    nan = a.is_nan | b.is_nan;
    if (op == OP_ADD) nan = nan | (a.is_inf & b.is_inf & (a.sign ^ b.sign));
    else              nan = nan | (a.is_inf & b.is_zero) | (a.is_zero & b.is_inf);
    inf      = a.is_inf | b.is_inf;
    inf_sign = (op == OP_MUL) ? (a.sign ^ b.sign) : (a.is_inf ? a.sign : b.sign);

    res_d   = (fmt == FMT_SINGLE) ? single_res : half_res;
    flags_d = (fmt == FMT_SINGLE) ? single_flags : half_flags;
    if (nan) begin
      res_d   = (fmt == FMT_SINGLE) ? S_QNAN : H_QNAN;
      flags_d = '0;
      flags_d[FLAG_I] = 1'b1;
    end else if (inf) begin
      res_d   = (fmt == FMT_SINGLE) ? {inf_sign, S_INF[30:0]} : {16'b0, inf_sign, H_INF[14:0]};
      flags_d = '0;
      flags_d[FLAG_N] = inf_sign;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign bus.Result   = res_q;
  assign bus.fpuFlags = flags_q;
endmodule

// File: tb/tb_fpu.sv
// tb/tb_fpu.sv - directed vectors, reset corners and randomized checks for fpu
module tb_fpu;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  fpu_if bus ();
  fpu dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic        fmt;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  vec_t vecs[18];

  // Value = mag * 2^e2, rounded to nearest-even at the target precision
  function automatic logic [35:0] pack_ref(input logic s, input longint mag, input int e2, input logic fmt);
    int mw, bias, emax, n, sh, e, be;
    longint q, rem, half;
    logic [31:0] r;
    logic [3:0] f;
    mw = fmt ? 23 : 10;
    bias = fmt ? 127 : 15;
    emax = fmt ? 255 : 31;
    r = '0;
    f = '0;
    q = 0;
    be = 0;
    if (mag != 0) begin
      n = 0;
      while ((mag >> n) != 0) n++;
      e = e2 + n - 1;
      sh = n - (mw + 1);
      if (sh > 0) begin
        q = mag >> sh;
        rem = mag - (q << sh);
        half = longint'(1) << (sh - 1);
        if (rem > half || (rem == half && q[0])) q++;
        if (q == (longint'(1) << (mw + 1))) begin
          q = q >> 1;
          e++;
        end
      end else begin
        q = mag << (-sh);
      end
      be = e + bias;
    end
    f[3] = s;
    if (mag != 0 && be >= emax) begin
      r = fmt ? 32'h7F80_0000 : 32'h0000_7C00;
      f[1] = 1'b1;
    end else if (be <= 0) begin
      f[2] = 1'b1;
    end else begin
      r = 32'((longint'(be) << mw) | (q - (longint'(1) << mw)));
    end
    if (s) r = r | (fmt ? 32'h8000_0000 : 32'h0000_8000);
    return {f, r};
  endfunction

  function automatic logic [35:0] ref_model(input logic op, input logic fmt, input logic [31:0] a, input logic [31:0] b);
    int mw, bias, emax, ea, eb, e0;
    logic sa, sb, s, nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
    longint fa, fb, ma, mb, va, vb, sum;
    logic [31:0] r;
    mw = fmt ? 23 : 10;
    bias = fmt ? 127 : 15;
    emax = fmt ? 255 : 31;
    if (fmt) begin
      sa = a[31]; ea = int'(a[30:23]); fa = longint'(a[22:0]);
      sb = b[31]; eb = int'(b[30:23]); fb = longint'(b[22:0]);
    end else begin
      sa = a[15]; ea = int'(a[14:10]); fa = longint'(a[9:0]);
      sb = b[15]; eb = int'(b[14:10]); fb = longint'(b[9:0]);
    end
    nan_a = (ea == emax) && (fa != 0);
    nan_b = (eb == emax) && (fb != 0);
    inf_a = (ea == emax) && (fa == 0);
    inf_b = (eb == emax) && (fb == 0);
    zero_a = (ea == 0);
    zero_b = (eb == 0);
    if (nan_a || nan_b || (!op && inf_a && inf_b && sa != sb) ||
        (op && ((inf_a && zero_b) || (zero_a && inf_b))))
      return {4'b0001, fmt ? 32'h7FC0_0000 : 32'h0000_7E00};
    if (inf_a || inf_b) begin
      s = op ? (sa ^ sb) : (inf_a ? sa : sb);
      r = fmt ? {s, 31'h7F80_0000} : {16'h0, s, 15'h7C00};
      return {s, 3'b000, r};
    end
    ma = zero_a ? 0 : fa + (longint'(1) << mw);
    mb = zero_b ? 0 : fb + (longint'(1) << mw);
    if (op) return pack_ref(sa ^ sb, ma * mb, ea + eb - 2 * (bias + mw), fmt);
    if (ma == 0 && mb == 0) return pack_ref(sa & sb, 0, 0, fmt);
    if (ea - eb > 30) return pack_ref(sa, ma, ea - bias - mw, fmt);
    if (eb - ea > 30) return pack_ref(sb, mb, eb - bias - mw, fmt);
    e0 = (ea < eb) ? ea : eb;
    va = ma << (ea - e0);
    vb = mb << (eb - e0);
    sum = (sa ? -va : va) + (sb ? -vb : vb);
    if (sum == 0) return pack_ref(1'b0, 0, 0, fmt);
    if (sum < 0) return pack_ref(1'b1, -sum, e0 - bias - mw, fmt);
    return pack_ref(1'b0, sum, e0 - bias - mw, fmt);
  endfunction

  function automatic logic [31:0] rand_operand(input logic fmt);
    logic [31:0] x;
    int k;
    x = $urandom;
    k = $urandom_range(0, 15);
    if (fmt) begin
      case (k)
        0: x[30:0] = '0;
        1: x[30:23] = 8'h00;
        2: x[30:23] = 8'hFF;
        3: x[30:0] = {8'hFF, 23'h0};
        4: ;
        5: x[30:23] = 8'($urandom_range(230, 254));
        6: x[30:23] = 8'($urandom_range(1, 20));
        default: x[30:23] = 8'($urandom_range(107, 147));
      endcase
    end else begin
      case (k)
        0: x[14:0] = '0;
        1: x[14:10] = 5'h00;
        2: x[14:10] = 5'h1F;
        3: x[14:0] = {5'h1F, 10'h0};
        4: ;
        5: x[14:10] = 5'($urandom_range(25, 30));
        6: x[14:10] = 5'($urandom_range(1, 5));
        default: x[14:10] = 5'($urandom_range(10, 20));
      endcase
    end
    return x;
  endfunction

  task automatic drive(input logic op, input logic fmt, input logic [31:0] a, input logic [31:0] b);
    bus.fpucontrol = op;
    bus.floatType = fmt;
    bus.A = a;
    bus.B = b;
  endtask

  task automatic check(input string name, input logic [31:0] want_r, input logic [3:0] want_f);
    total++;
    if (bus.Result !== want_r || bus.fpuFlags !== want_f) begin
      bad++;
      $display("FAIL %s: got Result=%h flags=%b, want Result=%h flags=%b",
               name, bus.Result, bus.fpuFlags, want_r, want_f);
    end
  endtask

  initial begin
    logic [35:0] exp_v;
    logic [31:0] ra, rb;
    logic rop, rfmt;

    vecs[0]  = '{1'b0, 1'b0, 32'h0000_3BFF, 32'h0000_3555, 32'h0000_3D55, 4'b0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_D482, 32'h0000_5664, 32'h0000_EF34, 4'b1000};
    vecs[2]  = '{1'b0, 1'b1, 32'h4020_0000, 32'h418C_0000, 32'h41A0_0000, 4'b0000};
    vecs[3]  = '{1'b0, 1'b1, 32'h418C_0000, 32'hC18C_0000, 32'h0000_0000, 4'b0100};
    vecs[4]  = '{1'b1, 1'b1, 32'hC060_0000, 32'h418C_0000, 32'hC275_0000, 4'b1000};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_7BFF, 32'h0000_7BFF, 32'h0000_7C00, 4'b0010};
    vecs[6]  = '{1'b0, 1'b1, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b0001};
    vecs[7]  = '{1'b0, 1'b0, 32'hFFFF_3C00, 32'h1234_3C00, 32'h0000_4000, 4'b0000};
    vecs[8]  = '{1'b1, 1'b0, 32'h0000_8000, 32'h0000_3C00, 32'h0000_8000, 4'b1100};
    vecs[9]  = '{1'b1, 1'b1, 32'h0000_0000, 32'h7F80_0000, 32'h7FC0_0000, 4'b0001};
    vecs[10] = '{1'b0, 1'b1, 32'hFF80_0000, 32'h3F80_0000, 32'hFF80_0000, 4'b1000};
    vecs[11] = '{1'b0, 1'b0, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 4'b0100};
    vecs[12] = '{1'b1, 1'b1, 32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0100};
    vecs[13] = '{1'b1, 1'b0, 32'h0000_7C01, 32'h0000_3C00, 32'h0000_7E00, 4'b0001};
    vecs[14] = '{1'b0, 1'b1, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 4'b0000};
    vecs[15] = '{1'b0, 1'b1, 32'h3F80_0001, 32'h3380_0000, 32'h3F80_0002, 4'b0000};
    vecs[16] = '{1'b0, 1'b0, 32'h0000_8000, 32'h0000_8000, 32'h0000_8000, 4'b1100};
    vecs[17] = '{1'b1, 1'b1, 32'h7F7F_FFFF, 32'h3F80_0000, 32'h7F7F_FFFF, 4'b0000};

    reset = 1'b1;
    drive(1'b1, 1'b1, 32'h3F80_0000, 32'h3F80_0000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'h0, 4'b0000);

    reset = 1'b0;
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].op, vecs[i].fmt, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].r, vecs[i].f);
    end

    drive(vecs[4].op, vecs[4].fmt, vecs[4].a, vecs[4].b);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_priority", 32'h0, 4'b0000);
    reset = 1'b0;
    drive(vecs[1].op, vecs[1].fmt, vecs[1].a, vecs[1].b);
    @(posedge clk);
    #1;
    check("first_after_reset", vecs[1].r, vecs[1].f);

    for (int i = 0; i < 3000; i++) begin
      rop = 1'($urandom_range(0, 1));
      rfmt = 1'($urandom_range(0, 1));
      ra = rand_operand(rfmt);
      rb = rand_operand(rfmt);
      if ($urandom_range(0, 4) == 0)
        rb = ra ^ (rfmt ? 32'h8000_0000 : 32'h0000_8000) ^ 32'($urandom_range(0, 7));
      exp_v = ref_model(rop, rfmt, ra, rb);
      drive(rop, rfmt, ra, rb);
      @(posedge clk);
      #1;
      check($sformatf("rand%0d op=%0d fmt=%0d a=%h b=%h", i, rop, rfmt, ra, rb), exp_v[31:0], exp_v[35:32]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu.md
FPU -- requirements
Module: fpu

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 fpucontrol  input  1  operation select: 0 = add (A+B), 1 = multiply (A*B).
REQ-004 A  input  32  operand A; single: all 32 bits; half: bits [15:0] only.
REQ-005 B  input  32  operand B; same encoding as A.
REQ-006 floatType  input  1  format: 0 = IEEE-754 binary16, 1 = IEEE-754 binary32.
REQ-007 fpuFlags  output  4  [3]=N (result sign), [2]=Z (result is ±0), [1]=V (overflow to ±inf from finite operands), [0]=I (invalid, NaN result).
REQ-008 Result  output  32  result; half: bits [15:0], bits [31:16] SHALL be 0.

Function
REQ-009 Inputs SHALL be sampled on each rising clk edge; Result/fpuFlags SHALL be registered and valid after that same edge (1-cycle latency, new operation every cycle, no handshake).
REQ-010 Half mode SHALL ignore A[31:16] and B[31:16].
REQ-011 Add SHALL align exponents, add/subtract significands by sign, normalize, and round with guard/round/sticky bits.
REQ-012 Multiply SHALL XOR signs, add unbiased exponents, multiply 11x11 (half) or 24x24 (single) significands, normalize, and round.
REQ-013 Rounding SHALL be round-to-nearest, ties-to-even, in both formats.
REQ-014 Subnormal inputs SHALL be treated as ±0; results below the minimum normal SHALL flush to ±0 (sign preserved).
REQ-015 Finite results exceeding max normal SHALL be ±infinity with V=1.
REQ-016 Any NaN operand, inf−inf (add), or 0×inf (mul) SHALL give canonical qNaN (half 0x7E00, single 0x7FC00000) with I=1, N=0.
REQ-017 inf with a finite operand SHALL propagate ±inf (sign per operation), V=0.
REQ-018 Exact cancellation in add SHALL give +0; multiply of zeros SHALL give a signed zero (XOR of signs).
REQ-019 N SHALL equal the result sign bit (0 for NaN); Z=1 iff the result is ±0.

Reset
REQ-020 While reset is high at a rising edge, Result SHALL become 0x00000000 and fpuFlags 4'b0000; reset SHALL take priority over any operation in that cycle.
REQ-021 The first operation after reset deasserts SHALL be processed normally, its result appearing one edge later.

Structure
REQ-022 A shared package SHALL hold format constants: exponent/mantissa widths, biases (15, 127), max exponents, canonical NaN and infinity patterns, and the flag bit indices.
REQ-023 Normalize/round/pack SHALL be one sub-module, fpu_round_pack, parameterized by format and shared by the add and multiply paths; the rest stays in fpu.

Verification
REQ-024 Half add: A=0x3BFF, B=0x3555, fpucontrol=0, floatType=0 -> Result=0x00003D55, flags=0000.
REQ-025 Half mul: A=0xD482, B=0x5664, fpucontrol=1, floatType=0 -> Result=0x0000EF34, flags=1000.
REQ-026 Single add: A=0x40200000 (2.5), B=0x418C0000 (17.5) -> Result=0x41A00000, flags=0000; A=0x418C0000, B=0xC18C0000 -> 0x00000000, flags=0100.
REQ-027 Single mul: A=0xC0600000 (-3.5), B=0x418C0000 (17.5) -> Result=0xC2750000, flags=1000.
REQ-028 Specials: half 0x7BFF*0x7BFF -> 0x00007C00, flags=0010; single 0x7F800000+0xFF800000 -> 0x7FC00000, flags=0001.
REQ-029 Reset: apply an operation and assert reset in the same cycle -> Result=0, flags=0000 after the edge; the next operation's result appears one cycle after reset deasserts.
